// File: rtl/rom_sched_pkg.sv
// Shared types for the template ROM read scheduler: FSM states, id width helper and return-pipe entry.
package rom_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Widest requester id the pipe entry must carry (NREQ up to 8).
  localparam int unsigned PIPE_ID_W = 3;

  function automatic int unsigned id_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [PIPE_ID_W-1:0] id;
  } ret_ent_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = ID_W'((int'(ptr) + i) % int'(NREQ));
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/template_rom_read_scheduler.sv
// Shares one sync-read template ROM between NREQ burst requesters (round-robin, one burst at a time).
// Optional per-burst byte checksum outputs when TEMPLATE_ROM_CHECKSUM_EN is defined.
module template_rom_read_scheduler
  import rom_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned LEN_WIDTH  = 11,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          tb_rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NREQ*LEN_WIDTH-1:0]     req_len,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  output logic                          rom_rd_en,
  input  logic [DATA_WIDTH-1:0]         rom_rd_data,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [id_w(NREQ)-1:0]         rd_id,
  output logic                          rd_last,
  output logic                          busy
`ifdef TEMPLATE_ROM_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH+LEN_WIDTH-1:0] burst_sum,
  output logic                            burst_sum_valid
`endif
);

  localparam int unsigned ID_W  = id_w(NREQ);
  localparam int unsigned DRN_W = 4;

  state_e                 state_q, state_nx;
  logic [NREQ-1:0]        req_ready_nx;
  logic [ADDR_WIDTH-1:0]  rom_addr_nx;
  logic                   rom_rd_en_nx;
  logic [LEN_WIDTH-1:0]   len_q, len_nx, cnt_q, cnt_nx;
  logic [ID_W-1:0]        id_q, id_nx, ptr_q, ptr_nx;
  logic                   last_q, last_nx;
  logic [DRN_W-1:0]       drain_q, drain_nx;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic [NREQ-1:0]        arb_grant;
  logic [ID_W-1:0]        arb_idx;
  logic                   arb_any;
  ret_ent_t               issue_ent, pipe_out;
  ret_ent_t               pipe_q [RD_LAT];
  logic                   pipe_id_unused;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Pick the granted requester's burst descriptor.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (arb_grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx     = state_q;
    req_ready_nx = '0;
    rom_addr_nx  = rom_addr;
    rom_rd_en_nx = 1'b0;
    len_nx       = len_q;
    cnt_nx       = cnt_q;
    id_nx        = id_q;
    ptr_nx       = ptr_q;
    last_nx      = 1'b0;
    drain_nx     = drain_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_nx     = ISSUE;
          req_ready_nx = arb_grant;
          rom_addr_nx  = sel_addr;
          rom_rd_en_nx = 1'b1;
          len_nx       = sel_len;
          cnt_nx       = '0;
          id_nx        = arb_idx;
          ptr_nx       = (int'(arb_idx) == int'(NREQ) - 1) ? '0 : ID_W'(arb_idx + 1'b1);
          last_nx      = (sel_len == '0);
        end
      end
      ISSUE: begin
        if (cnt_q == len_q) begin
          state_nx = DRAIN;
          drain_nx = '0;
        end else begin
          cnt_nx       = LEN_WIDTH'(cnt_q + 1'b1);
          rom_addr_nx  = ADDR_WIDTH'(rom_addr + 1'b1);
          rom_rd_en_nx = 1'b1;
          last_nx      = (LEN_WIDTH'(cnt_q + 1'b1) == len_q);
        end
      end
      DRAIN: begin
        if (drain_q == DRN_W'(RD_LAT - 1)) state_nx = IDLE;
        else                               drain_nx = DRN_W'(drain_q + 1'b1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      req_ready <= '0;
      rom_addr  <= '0;
      rom_rd_en <= 1'b0;
      busy      <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      last_q    <= 1'b0;
      drain_q   <= '0;
    end else begin
      req_ready <= req_ready_nx;
      rom_addr  <= rom_addr_nx;
      rom_rd_en <= rom_rd_en_nx;
      busy      <= (state_nx != IDLE);
      len_q     <= len_nx;
      cnt_q     <= cnt_nx;
      id_q      <= id_nx;
      ptr_q     <= ptr_nx;
      last_q    <= last_nx;
      drain_q   <= drain_nx;
    end
  end

  // Return pipe tracks the issued beat until its ROM data appears.
  assign issue_ent = {rom_rd_en, last_q & rom_rd_en, rom_rd_en ? PIPE_ID_W'(id_q) : PIPE_ID_W'(0)};

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= issue_ent;
      for (int i = 1; i < int'(RD_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_out       = pipe_q[RD_LAT-1];
  assign rd_valid       = pipe_out.valid;
  assign rd_last        = pipe_out.last;
  assign rd_id          = pipe_out.id[ID_W-1:0];
  assign rd_data        = rd_valid ? rom_rd_data : '0;
  assign pipe_id_unused = ^pipe_out.id;

`ifdef TEMPLATE_ROM_CHECKSUM_EN
  localparam int unsigned SUM_W = DATA_WIDTH + LEN_WIDTH;

  logic [SUM_W-1:0] acc_q;

  // Accumulator holds the finished sum until the next grant clears it.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)                          acc_q <= '0;
    else if (state_q == IDLE && arb_any) acc_q <= '0;
    else if (rd_valid)                   acc_q <= SUM_W'(acc_q + SUM_W'(rd_data));
  end

  assign burst_sum       = SUM_W'(acc_q + SUM_W'(rd_data));
  assign burst_sum_valid = rd_valid & rd_last;
`endif

endmodule
